// File: rtl/brlite_tx_arbiter.sv
// Round-robin arbiter that shares the single BrLite local output port between NREQ requesters.
// The payload is latched at grant. A watchdog aborts a request that BrLite never acknowledges.
module brlite_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 74,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*DATA_W-1:0] data_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [NREQ-1:0]        err_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    input  logic                   br_local_busy_i,
    output logic                   br_req_o,
    input  logic                   br_ack_i,
    output logic [DATA_W-1:0]      br_data_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e                        state_q;
    logic   [IW-1:0]               ptr_q, win_q, win_d, cand, ptr_nxt;
    logic   [CW-1:0]               cnt_q;
    logic   [NREQ-1:0]             ack_q, err_q, grant_q;
    logic                          br_req_q;
    logic   [DATA_W-1:0]           br_data_q;
    logic   [NREQ-1:0][DATA_W-1:0] data_a;
    logic                          found;

    assign data_a  = data_i;
    assign ptr_nxt = IW'((int'(win_q) + 1) % NREQ);

    // First pending requester at or after the rr pointer, wrapping around.
    always_comb begin
        win_d = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win_d = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            grant_q   <= '0;
            br_req_q  <= 1'b0;
            br_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i && !br_local_busy_i) begin
                        win_q     <= win_d;
                        br_data_q <= data_a[win_d];
                        grant_q   <= NREQ'(1) << win_d;
                        br_req_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    // An ack on the timeout cycle still counts as a clean completion.
                    if (br_ack_i) begin
                        br_req_q     <= 1'b0;
                        ack_q[win_q] <= 1'b1;
                        ptr_q        <= ptr_nxt;
                        state_q      <= DONE;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        br_req_q     <= 1'b0;
                        ack_q[win_q] <= 1'b1;
                        err_q[win_q] <= 1'b1;
                        ptr_q        <= ptr_nxt;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);
    assign br_req_o  = br_req_q;
    assign br_data_o = br_data_q;

endmodule
